// File: rtl/iob_sync_asym_fifo_pkg.sv
// Shared width arithmetic for the asymmetric FIFO family (sync and future async variants).
package iob_sync_asym_fifo_pkg;

  function automatic int min_w(input int a, input int b);
    return (a < b) ? a : b;
  endfunction

  function automatic int max_w(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

  function automatic int ratio(input int a, input int b);
    return max_w(a, b) / min_w(a, b);
  endfunction

  // Width in MIN_W units of one port word
  function automatic int units(input int port_w, input int a, input int b);
    return port_w / min_w(a, b);
  endfunction

  function automatic bit is_pow2(input int v);
    return (v > 0) && ((v & (v - 1)) == 0);
  endfunction

  function automatic int log2c(input int v);
    return $clog2(v);
  endfunction

endpackage

// File: rtl/iob_t2p_asym_ram.sv
// Two-port asymmetric RAM addressed in MIN_W units; wide ports touch consecutive
// narrow entries, lowest address in the least significant slice. Registered read.
module iob_t2p_asym_ram
  import iob_sync_asym_fifo_pkg::*;
#(
  parameter int W_DATA_W = 32,
  parameter int R_DATA_W = 8,
  parameter int ADDR_W   = 6
) (
  input  logic                w_clk,
  input  logic                w_en,
  input  logic [ADDR_W-1:0]   w_addr,
  input  logic [W_DATA_W-1:0] w_data,
  input  logic                r_clk,
  input  logic                r_en,
  input  logic [ADDR_W-1:0]   r_addr,
  output logic [R_DATA_W-1:0] r_data
);
  localparam int MIN_W = min_w(W_DATA_W, R_DATA_W);
  localparam int WU    = units(W_DATA_W, W_DATA_W, R_DATA_W);
  localparam int RU    = units(R_DATA_W, W_DATA_W, R_DATA_W);

  logic [MIN_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge w_clk) begin
    if (w_en)
      for (int i = 0; i < WU; i++)
        mem[w_addr + ADDR_W'(i)] <= w_data[i*MIN_W +: MIN_W];
  end

  always_ff @(posedge r_clk) begin
    if (r_en)
      for (int i = 0; i < RU; i++)
        r_data[i*MIN_W +: MIN_W] <= mem[r_addr + ADDR_W'(i)];
  end

endmodule

// File: rtl/iob_sync_asym_fifo.sv
// Single-clock FIFO with differing write/read widths; occupancy kept in MIN_W units.
// Define IOB_SYNC_ASYM_FIFO_ALMOST_EN to add registered almost_full/almost_empty.
module iob_sync_asym_fifo
  import iob_sync_asym_fifo_pkg::*;
#(
  parameter int W_DATA_W        = 32,
  parameter int R_DATA_W        = 8,
  parameter int ADDR_W          = 6,
  parameter int ALMOST_FULL_TH  = 4,
  parameter int ALMOST_EMPTY_TH = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                w_en,
  input  logic [W_DATA_W-1:0] w_data,
  output logic                w_full,
  input  logic                r_en,
  output logic [R_DATA_W-1:0] r_data,
  output logic                r_empty,
  output logic [ADDR_W:0]     level
`ifdef IOB_SYNC_ASYM_FIFO_ALMOST_EN
  ,
  output logic                almost_full,
  output logic                almost_empty
`endif
);
  localparam int DEPTH = 2**ADDR_W;
  localparam int RATIO = ratio(W_DATA_W, R_DATA_W);
  localparam int WU    = units(W_DATA_W, W_DATA_W, R_DATA_W);
  localparam int RU    = units(R_DATA_W, W_DATA_W, R_DATA_W);

  localparam logic [ADDR_W:0] WU_L    = (ADDR_W+1)'(WU);
  localparam logic [ADDR_W:0] RU_L    = (ADDR_W+1)'(RU);
  localparam logic [ADDR_W:0] FULL_TH = (ADDR_W+1)'(DEPTH - WU);

  if (!is_pow2(RATIO) || (RATIO * min_w(W_DATA_W, R_DATA_W) != max_w(W_DATA_W, R_DATA_W)))
    begin : g_bad_ratio
      $error("width ratio must be a power of two");
    end
  if (DEPTH < 2 * RATIO || log2c(DEPTH) != ADDR_W) begin : g_bad_depth
    $error("2**ADDR_W must be at least twice the width ratio");
  end
  if (ALMOST_FULL_TH < 0 || ALMOST_FULL_TH > DEPTH ||
      ALMOST_EMPTY_TH < 0 || ALMOST_EMPTY_TH > DEPTH) begin : g_bad_th
    $error("almost thresholds out of range");
  end

  logic [ADDR_W-1:0] w_ptr, r_ptr;
  logic [ADDR_W:0]   level_nxt;
  logic              w_acc, r_acc;

  // Flags come straight off the registered level so reset forces them at once
  assign w_full  = level > FULL_TH;
  assign r_empty = level < RU_L;
  assign w_acc   = w_en & ~w_full;
  assign r_acc   = r_en & ~r_empty;

  always_comb begin
    level_nxt = level + (w_acc ? WU_L : '0) - (r_acc ? RU_L : '0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_ptr <= '0;
      r_ptr <= '0;
      level <= '0;
    end else begin
      if (w_acc) w_ptr <= w_ptr + ADDR_W'(WU);
      if (r_acc) r_ptr <= r_ptr + ADDR_W'(RU);
      level <= level_nxt;
    end
  end

`ifdef IOB_SYNC_ASYM_FIFO_ALMOST_EN
  localparam logic [ADDR_W:0] AF_L = (ADDR_W+1)'(DEPTH - ALMOST_FULL_TH);
  localparam logic [ADDR_W:0] AE_L = (ADDR_W+1)'(ALMOST_EMPTY_TH);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      almost_full  <= 1'b0;
      almost_empty <= 1'b1;
    end else begin
      almost_full  <= level_nxt >= AF_L;
      almost_empty <= level_nxt <= AE_L;
    end
  end
`endif

  // Pointers only advance on accepted requests, so the RAM never sees a blocked access
  iob_t2p_asym_ram #(
    .W_DATA_W(W_DATA_W),
    .R_DATA_W(R_DATA_W),
    .ADDR_W  (ADDR_W)
  ) u_ram (
    .w_clk (clk),
    .w_en  (w_acc),
    .w_addr(w_ptr),
    .w_data(w_data),
    .r_clk (clk),
    .r_en  (r_acc),
    .r_addr(r_ptr),
    .r_data(r_data)
  );

endmodule

// File: doc/iob_sync_asym_fifo.md
IOB_SYNC_ASYM_FIFO -- requirements
Module: iob_sync_asym_fifo

Interface
REQ-001 SHALL have parameter W_DATA_W, default 32, write word width in bits.
REQ-002 SHALL have parameter R_DATA_W, default 8, read word width in bits.
REQ-003 SHALL have parameter ADDR_W, default 6, log2 of depth counted in MIN_W=min(W_DATA_W,R_DATA_W) units.
REQ-004 SHALL have parameters ALMOST_FULL_TH, default 4, and ALMOST_EMPTY_TH, default 4, both in MIN_W units and used only under REQ-024.
REQ-005 SHALL have ports: clk in 1, the single clock; rst_n in 1, reset, asynchronous active-low.
REQ-006 SHALL have ports: w_en in 1, write request; w_data in W_DATA_W, write word; w_full out 1, write blocked.
REQ-007 SHALL have ports: r_en in 1, read request; r_data out R_DATA_W, read word; r_empty out 1, read blocked.
REQ-008 SHALL have port level out ADDR_W+1, occupancy in MIN_W units.
REQ-009 SHALL have ports almost_full out 1 and almost_empty out 1, present only under REQ-024.

Function
REQ-010 SHALL require max/min width ratio RATIO to be a power of two (1 allowed) and 2**ADDR_W >= 2*RATIO; else elaboration error.
REQ-011 SHALL define WU=W_DATA_W/MIN_W and RU=R_DATA_W/MIN_W; each accepted write adds WU to level, each accepted read removes RU.
REQ-012 SHALL accept a write when w_en=1 and w_full=0; a write with w_full=1 SHALL change no state.
REQ-013 SHALL accept a read when r_en=1 and r_empty=0; a read with r_empty=1 SHALL change no state and SHALL leave r_data unchanged.
REQ-014 SHALL drive w_full=1 iff level > 2**ADDR_W-WU, and r_empty=1 iff level < RU, both decoded from the registered level.
REQ-015 SHALL present r_data for an accepted read exactly one clk cycle after acceptance and SHALL hold it until the next accepted read.
REQ-016 SHALL, on a simultaneous accepted write and read, update level by WU-RU in one cycle.
REQ-017 SHALL make written data readable no earlier than the cycle after the write; no same-cycle write-to-read bypass.
REQ-018 SHALL order narrow items little-endian: the first narrow item written or read maps to bits [MIN_W-1:0] of the wide word.
REQ-019 SHALL keep write and read pointers in MIN_W units, advancing by WU and RU and wrapping modulo 2**ADDR_W.

Reset
REQ-020 SHALL, while rst_n=0, immediately force pointers and level to 0, r_empty=1, w_full=0, almost_empty=1 and almost_full=0.
REQ-021 SHALL leave r_data undefined from reset until the first accepted read.
REQ-022 SHALL discard all stored data on reset mid-operation; no pre-reset data is readable afterwards.
REQ-023 SHALL accept requests on the first clk rising edge after rst_n deasserts.

Configuration
REQ-024 SHALL, with macro IOB_SYNC_ASYM_FIFO_ALMOST_EN defined, provide registered almost_full=1 iff level >= 2**ADDR_W-ALMOST_FULL_TH and almost_empty=1 iff level <= ALMOST_EMPTY_TH, updated in the same cycle as level.
REQ-025 SHALL, without that macro, omit almost_full, almost_empty and their logic entirely.

Structure
REQ-026 SHALL place derived constants (MIN_W, RATIO, WU, RU, log2 helpers) in a shared package for reuse by later FIFO variants.
REQ-027 SHALL use one sub-module for storage, the team's two-port asymmetric RAM iob_t2p_asym_ram, with both its clocks tied to clk; pointer, level and flag logic stay in this block.

Verification
REQ-028 W=32,R=8,ADDR_W=4: release reset -> level=0, r_empty=1, w_full=0.
REQ-029 Write 0x44332211 -> next cycle level=4; four reads return 0x11,0x22,0x33,0x44 each one cycle after acceptance; then level=0, r_empty=1.
REQ-030 Write four words -> level=16, w_full=1; fifth write ignored; one read -> level=15, w_full=1; three more reads -> level=12, w_full=0.
REQ-031 At level=8, w_en and r_en together -> level=11; with rst_n pulsed low at level=8 -> level=0 and r_empty=1 immediately.
REQ-032 W=8,R=32: write 0xA0..0xA3 -> r_empty=1 after three writes and 0 after the fourth; read returns 0xA3A2A1A0.
REQ-033 200 cycles of random w_en/r_en with scoreboard across pointer wrap, both macro settings -> no data mismatch, flags match model every cycle.
